// File: rtl/spmv_pkg.sv
// Shared constants for the SpMV HBM datapath: HBM port geometry and the fixed
// AXI burst encodings used by every read engine.
package spmv_pkg;

  localparam int         HBM_ADDR_W     = 48;
  localparam int         HBM_DATA_W     = 256;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;

  // Index width that stays legal (>= 1 bit) for a single-entry set.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hbm_rd_arbiter_if.sv
// Shared HBM AXI4 read port (AR + R channels): master is the arbiter side,
// slave is the memory side.
interface hbm_rd_arbiter_if #(
  parameter int ADDR_W = spmv_pkg::HBM_ADDR_W,
  parameter int DATA_W = spmv_pkg::HBM_DATA_W
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/hbm_rd_route_fifo.sv
// In-order FIFO of requester indices, one entry per issued burst; the head
// names the requester that owns the R data currently on the shared port.
module hbm_rd_route_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  import spmv_pkg::*;

  localparam int PTR_W = idx_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             full_s;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_s = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head   = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-state pointers and storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full_s) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// Round-robin arbiter sharing one HBM AXI4 read port among NUM_REQ kernel
// requesters; R bursts return to their owners in issue order.
module hbm_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = spmv_pkg::HBM_ADDR_W,
  parameter int DATA_W    = spmv_pkg::HBM_DATA_W,
  parameter int MAX_OUTST = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  output logic [NUM_REQ*DATA_W-1:0] s_rdata,
  output logic [NUM_REQ*2-1:0]      s_rresp,
  output logic [NUM_REQ-1:0]        s_rlast,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      err_unexp_r
);
  import spmv_pkg::*;

  localparam int               IDX_W   = idx_width(NUM_REQ);
  localparam int               CNT_W   = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic               arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [IDX_W-1:0]   aridx_q, aridx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               err_q, err_d;

  logic               found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               grant_s;
  logic               ar_hs_s;
  logic               r_last_hs_s;
  logic               fifo_empty_s;
  logic [IDX_W-1:0]   fifo_head_s;

  // Round-robin search starting just after the previous winner
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             hit;
    cand      = 0;
    cand_idx  = '0;
    hit       = 1'b0;
    found_s   = 1'b0;
    win_idx_s = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand      = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx  = IDX_W'(cand);
      hit       = !found_s && s_arvalid[cand_idx];
      win_idx_s = hit ? cand_idx : win_idx_s;
      found_s   = found_s | hit;
    end
  end

  // The stage may be refilled in the same cycle it hands off to HBM.
  assign ar_hs_s     = arvalid_q && m_axi_arready;
  assign grant_s     = rstn && (!arvalid_q || m_axi_arready) &&
                       (outst_q < MAX_CNT) && found_s;
  assign s_arready   = grant_s ? (NUM_REQ'(1) << win_idx_s) : '0;

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arsize  = AXI_SIZE_32B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign err_unexp_r   = err_q;

  // R data is steered by the oldest outstanding burst; no owner means stall.
  assign m_axi_rready = rstn && !fifo_empty_s && s_rready[fifo_head_s];
  assign r_last_hs_s  = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign s_rvalid     = (rstn && m_axi_rvalid && !fifo_empty_s) ?
                        (NUM_REQ'(1) << fifo_head_s) : '0;
  assign s_rdata      = rstn ? {NUM_REQ{m_axi_rdata}} : '0;
  assign s_rresp      = rstn ? {NUM_REQ{m_axi_rresp}} : '0;
  assign s_rlast      = rstn ? {NUM_REQ{m_axi_rlast}} : '0;

  // Next-state for the AR stage, priority pointer, burst count and error flag
  always_comb begin
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    aridx_d      = aridx_q;
    last_grant_d = last_grant_q;
    if (grant_s) begin
      arvalid_d    = 1'b1;
      araddr_d     = s_araddr[win_idx_s*ADDR_W +: ADDR_W];
      arlen_d      = s_arlen[win_idx_s*8 +: 8];
      aridx_d      = win_idx_s;
      last_grant_d = win_idx_s;
    end else if (ar_hs_s) begin
      arvalid_d = 1'b0;
    end else begin
      arvalid_d = arvalid_q;
    end
    case ({grant_s, r_last_hs_s})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
    err_d = err_q | (m_axi_rvalid && fifo_empty_s);
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= 8'd0;
      aridx_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      outst_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      aridx_q      <= aridx_d;
      last_grant_q <= last_grant_d;
      outst_q      <= outst_d;
      err_q        <= err_d;
    end
  end

  hbm_rd_route_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_route_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ar_hs_s),
    .push_data (aridx_q),
    .pop       (r_last_hs_s),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Directed bench for hbm_rd_arbiter: arbitration order, AR stall, outstanding
// limit, R routing with back-pressure, unexpected data and reset behaviour.
module tb_hbm_rd_arbiter;
  localparam int NR = 4;
  localparam int AW = 48;
  localparam int DW = 256;
  localparam int MO = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*AW-1:0] s_araddr;
  logic [NR*8-1:0]  s_arlen;
  logic [NR-1:0]    s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [NR*DW-1:0] s_rdata;
  logic [NR*2-1:0]  s_rresp;
  logic             err_unexp_r;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  hbm_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hbm ();

  always #5 clk = ~clk;

  hbm_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_araddr      (s_araddr),
    .s_arlen       (s_arlen),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rlast       (s_rlast),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .m_axi_araddr  (hbm.araddr),
    .m_axi_arlen   (hbm.arlen),
    .m_axi_arsize  (hbm.arsize),
    .m_axi_arburst (hbm.arburst),
    .m_axi_arvalid (hbm.arvalid),
    .m_axi_arready (hbm.arready),
    .m_axi_rdata   (hbm.rdata),
    .m_axi_rresp   (hbm.rresp),
    .m_axi_rlast   (hbm.rlast),
    .m_axi_rvalid  (hbm.rvalid),
    .m_axi_rready  (hbm.rready),
    .err_unexp_r   (err_unexp_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s_araddr    = '0;
    s_arlen     = '0;
    s_arvalid   = '0;
    s_rready    = '0;
    hbm.arready = 1'b0;
    hbm.rdata   = '0;
    hbm.rresp   = 2'b00;
    hbm.rlast   = 1'b0;
    hbm.rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    settle();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [7:0] len);
    s_araddr[i*AW +: AW] = addr;
    s_arlen[i*8 +: 8]    = len;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b1;
    #1;
    rstn = 1'b0;
    s_arvalid  = 4'hF;
    s_rready   = 4'hF;
    hbm.rvalid = 1'b1;
    #1;
    vec_cnt++; if (hbm.arvalid !== 1'b0) begin miss_cnt++; $display("FAIL rst_arvalid: got %0h want 0", hbm.arvalid); end
    vec_cnt++; if (s_arready !== 4'h0) begin miss_cnt++; $display("FAIL rst_s_arready: got %0h want 0", s_arready); end
    vec_cnt++; if (s_rvalid !== 4'h0) begin miss_cnt++; $display("FAIL rst_s_rvalid: got %0h want 0", s_rvalid); end
    vec_cnt++; if (hbm.rready !== 1'b0) begin miss_cnt++; $display("FAIL rst_rready: got %0h want 0", hbm.rready); end
    vec_cnt++; if (err_unexp_r !== 1'b0) begin miss_cnt++; $display("FAIL rst_err: got %0h want 0", err_unexp_r); end
    vec_cnt++; if (hbm.arsize !== 3'b101) begin miss_cnt++; $display("FAIL arsize: got %0h want 5", hbm.arsize); end
    vec_cnt++; if (hbm.arburst !== 2'b01) begin miss_cnt++; $display("FAIL arburst: got %0h want 1", hbm.arburst); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 48'h1000, 8'd3);
    s_arvalid   = 4'b0100;
    hbm.arready = 1'b1;
    settle();
    vec_cnt++; if (s_arready !== 4'b0100) begin miss_cnt++; $display("FAIL single_grant: got %0h want 4", s_arready); end
    vec_cnt++; if (hbm.arvalid !== 1'b0) begin miss_cnt++; $display("FAIL single_arvalid_early: got %0h want 0", hbm.arvalid); end
    tick();
    s_arvalid = 4'b0000;
    settle();
    vec_cnt++; if (hbm.arvalid !== 1'b1) begin miss_cnt++; $display("FAIL single_arvalid: got %0h want 1", hbm.arvalid); end
    vec_cnt++; if (hbm.araddr !== 48'h1000) begin miss_cnt++; $display("FAIL single_araddr: got %0h want 1000", hbm.araddr); end
    vec_cnt++; if (hbm.arlen !== 8'd3) begin miss_cnt++; $display("FAIL single_arlen: got %0h want 3", hbm.arlen); end
    tick();
    s_rready = 4'hF;
    for (int b = 0; b < 4; b++) begin
      hbm.rvalid = 1'b1;
      hbm.rdata  = DW'(32'hD000 + b);
      hbm.rlast  = (b == 3);
      settle();
      vec_cnt++; if (s_rvalid !== 4'b0100) begin miss_cnt++; $display("FAIL single_rvalid beat %0d: got %0h want 4", b, s_rvalid); end
      vec_cnt++; if (s_rdata[2*DW +: DW] !== DW'(32'hD000 + b)) begin miss_cnt++; $display("FAIL single_rdata beat %0d: got %0h want %0h", b, s_rdata[2*DW +: DW], 32'hD000 + b); end
      tick();
    end
    hbm.rvalid = 1'b0;
    hbm.rlast  = 1'b0;
    settle();
    vec_cnt++; if (err_unexp_r !== 1'b0) begin miss_cnt++; $display("FAIL single_err: got %0h want 0", err_unexp_r); end
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(48'h2000 + 48'h100 * i), 8'(i));
    s_arvalid   = 4'hF;
    hbm.arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      vec_cnt++; if (s_arready !== (4'b0001 << exp_order[k])) begin miss_cnt++; $display("FAIL rr_grant %0d: got %0h want %0h", k, s_arready, 4'b0001 << exp_order[k]); end
      if (k > 0) begin
        vec_cnt++; if (hbm.araddr !== AW'(48'h2000 + 48'h100 * exp_order[k-1])) begin miss_cnt++; $display("FAIL rr_araddr %0d: got %0h want %0h", k, hbm.araddr, 48'h2000 + 48'h100 * exp_order[k-1]); end
      end
      tick();
    end
    s_arvalid = 4'h0;
  endtask

  task automatic test_ar_stall();
    do_reset();
    set_req(1, 48'hABC000, 8'd7);
    set_req(0, 48'h5000, 8'd2);
    s_arvalid   = 4'b0010;
    hbm.arready = 1'b0;
    settle();
    vec_cnt++; if (s_arready !== 4'b0010) begin miss_cnt++; $display("FAIL stall_grant: got %0h want 2", s_arready); end
    tick();
    s_arvalid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      settle();
      vec_cnt++; if (hbm.arvalid !== 1'b1) begin miss_cnt++; $display("FAIL stall_arvalid %0d: got %0h want 1", c, hbm.arvalid); end
      vec_cnt++; if (hbm.araddr !== 48'hABC000) begin miss_cnt++; $display("FAIL stall_araddr %0d: got %0h want abc000", c, hbm.araddr); end
      vec_cnt++; if (hbm.arlen !== 8'd7) begin miss_cnt++; $display("FAIL stall_arlen %0d: got %0h want 7", c, hbm.arlen); end
      vec_cnt++; if (s_arready !== 4'b0000) begin miss_cnt++; $display("FAIL stall_s_arready %0d: got %0h want 0", c, s_arready); end
      tick();
    end
    hbm.arready = 1'b1;
    settle();
    vec_cnt++; if (s_arready !== 4'b0001) begin miss_cnt++; $display("FAIL b2b_grant: got %0h want 1", s_arready); end
    tick();
    s_arvalid = 4'b0000;
    settle();
    vec_cnt++; if (hbm.arvalid !== 1'b1) begin miss_cnt++; $display("FAIL b2b_arvalid: got %0h want 1", hbm.arvalid); end
    vec_cnt++; if (hbm.araddr !== 48'h5000) begin miss_cnt++; $display("FAIL b2b_araddr: got %0h want 5000", hbm.araddr); end
    vec_cnt++; if (hbm.arlen !== 8'd2) begin miss_cnt++; $display("FAIL b2b_arlen: got %0h want 2", hbm.arlen); end
  endtask

  task automatic test_outst_limit();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(48'h8000 + 48'h40 * i), 8'd0);
    s_arvalid   = 4'hF;
    s_rready    = 4'hF;
    hbm.arready = 1'b1;
    for (int k = 0; k < MO; k++) begin
      settle();
      vec_cnt++; if (s_arready !== (4'b0001 << (k % NR))) begin miss_cnt++; $display("FAIL outst_grant %0d: got %0h want %0h", k, s_arready, 4'b0001 << (k % NR)); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      settle();
      vec_cnt++; if (s_arready !== 4'b0000) begin miss_cnt++; $display("FAIL outst_block %0d: got %0h want 0", c, s_arready); end
      tick();
    end
    hbm.rvalid = 1'b1;
    hbm.rlast  = 1'b1;
    hbm.rdata  = DW'(32'h77);
    settle();
    vec_cnt++; if (s_rvalid !== 4'b0001) begin miss_cnt++; $display("FAIL outst_rvalid: got %0h want 1", s_rvalid); end
    vec_cnt++; if (hbm.rready !== 1'b1) begin miss_cnt++; $display("FAIL outst_rready: got %0h want 1", hbm.rready); end
    vec_cnt++; if (s_arready !== 4'b0000) begin miss_cnt++; $display("FAIL outst_block_hs: got %0h want 0", s_arready); end
    tick();
    hbm.rvalid = 1'b0;
    hbm.rlast  = 1'b0;
    settle();
    vec_cnt++; if (s_arready !== 4'b0001) begin miss_cnt++; $display("FAIL outst_unblock: got %0h want 1", s_arready); end
    tick();
    s_arvalid = 4'h0;
  endtask

  task automatic test_r_backpressure();
    do_reset();
    set_req(1, 48'h3000, 8'd2);
    set_req(3, 48'h4000, 8'd1);
    hbm.arready = 1'b1;
    s_arvalid   = 4'b0010;
    tick();
    s_arvalid = 4'b1000;
    tick();
    s_arvalid = 4'b0000;
    tick();
    tick();
    s_rready   = 4'hF;
    hbm.rvalid = 1'b1;
    hbm.rdata  = DW'(32'hA0);
    settle();
    vec_cnt++; if (s_rvalid !== 4'b0010) begin miss_cnt++; $display("FAIL bp_rvalid_a0: got %0h want 2", s_rvalid); end
    vec_cnt++; if (s_rdata[0 +: DW] !== DW'(32'hA0)) begin miss_cnt++; $display("FAIL bp_broadcast: got %0h want a0", s_rdata[0 +: DW]); end
    tick();
    hbm.rdata = DW'(32'hA1);
    s_rready  = 4'b0101;
    settle();
    vec_cnt++; if (hbm.rready !== 1'b0) begin miss_cnt++; $display("FAIL bp_rready_stall: got %0h want 0", hbm.rready); end
    vec_cnt++; if (s_rvalid !== 4'b0010) begin miss_cnt++; $display("FAIL bp_rvalid_stall: got %0h want 2", s_rvalid); end
    tick();
    s_rready = 4'hF;
    settle();
    vec_cnt++; if (hbm.rready !== 1'b1) begin miss_cnt++; $display("FAIL bp_rready_resume: got %0h want 1", hbm.rready); end
    vec_cnt++; if (s_rdata[1*DW +: DW] !== DW'(32'hA1)) begin miss_cnt++; $display("FAIL bp_rdata_a1: got %0h want a1", s_rdata[1*DW +: DW]); end
    tick();
    hbm.rdata = DW'(32'hA2);
    hbm.rlast = 1'b1;
    settle();
    vec_cnt++; if (s_rvalid !== 4'b0010) begin miss_cnt++; $display("FAIL bp_rvalid_a2: got %0h want 2", s_rvalid); end
    tick();
    hbm.rdata = DW'(32'hB0);
    hbm.rlast = 1'b0;
    settle();
    vec_cnt++; if (s_rvalid !== 4'b1000) begin miss_cnt++; $display("FAIL bp_rvalid_b0: got %0h want 8", s_rvalid); end
    vec_cnt++; if (s_rdata[3*DW +: DW] !== DW'(32'hB0)) begin miss_cnt++; $display("FAIL bp_rdata_b0: got %0h want b0", s_rdata[3*DW +: DW]); end
    tick();
    hbm.rdata = DW'(32'hB1);
    hbm.rlast = 1'b1;
    settle();
    vec_cnt++; if (s_rvalid !== 4'b1000) begin miss_cnt++; $display("FAIL bp_rvalid_b1: got %0h want 8", s_rvalid); end
    tick();
    hbm.rvalid = 1'b0;
    hbm.rlast  = 1'b0;
  endtask

  task automatic test_unexp_and_reset();
    do_reset();
    hbm.rvalid = 1'b1;
    hbm.rdata  = DW'(32'h55);
    s_rready   = 4'hF;
    settle();
    vec_cnt++; if (hbm.rready !== 1'b0) begin miss_cnt++; $display("FAIL unexp_rready: got %0h want 0", hbm.rready); end
    vec_cnt++; if (s_rvalid !== 4'b0000) begin miss_cnt++; $display("FAIL unexp_rvalid: got %0h want 0", s_rvalid); end
    tick();
    hbm.rvalid = 1'b0;
    tick();
    tick();
    vec_cnt++; if (err_unexp_r !== 1'b1) begin miss_cnt++; $display("FAIL unexp_err_sticky: got %0h want 1", err_unexp_r); end
    set_req(0, 48'h6000, 8'd3);
    set_req(1, 48'h7000, 8'd1);
    s_arvalid   = 4'b0001;
    hbm.arready = 1'b1;
    tick();
    s_arvalid = 4'b0000;
    tick();
    s_arvalid   = 4'b0010;
    hbm.arready = 1'b0;
    tick();
    s_arvalid  = 4'b0000;
    hbm.rvalid = 1'b1;
    hbm.rlast  = 1'b0;
    settle();
    vec_cnt++; if (s_rvalid !== 4'b0001) begin miss_cnt++; $display("FAIL midburst_rvalid: got %0h want 1", s_rvalid); end
    vec_cnt++; if (hbm.arvalid !== 1'b1) begin miss_cnt++; $display("FAIL midburst_arvalid: got %0h want 1", hbm.arvalid); end
    rstn      = 1'b0;
    s_arvalid = 4'hF;
    settle();
    vec_cnt++; if (hbm.arvalid !== 1'b0) begin miss_cnt++; $display("FAIL mrst_arvalid: got %0h want 0", hbm.arvalid); end
    vec_cnt++; if (s_arready !== 4'b0000) begin miss_cnt++; $display("FAIL mrst_s_arready: got %0h want 0", s_arready); end
    vec_cnt++; if (s_rvalid !== 4'b0000) begin miss_cnt++; $display("FAIL mrst_s_rvalid: got %0h want 0", s_rvalid); end
    vec_cnt++; if (hbm.rready !== 1'b0) begin miss_cnt++; $display("FAIL mrst_rready: got %0h want 0", hbm.rready); end
    vec_cnt++; if (err_unexp_r !== 1'b0) begin miss_cnt++; $display("FAIL mrst_err: got %0h want 0", err_unexp_r); end
    tick();
    clear_inputs();
    rstn = 1'b1;
    settle();
    hbm.rvalid = 1'b1;
    s_rready   = 4'hF;
    settle();
    vec_cnt++; if (hbm.rready !== 1'b0) begin miss_cnt++; $display("FAIL discard_rready: got %0h want 0", hbm.rready); end
    vec_cnt++; if (s_rvalid !== 4'b0000) begin miss_cnt++; $display("FAIL discard_rvalid: got %0h want 0", s_rvalid); end
    tick();
    hbm.rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_outst_limit();
    test_r_backpressure();
    test_unexp_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/hbm_rd_arbiter.md
HBM_RD_ARBITER -- requirements
Module: hbm_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of kernel read requesters sharing one HBM AXI4 read port.
REQ-002 SHALL have parameter ADDR_W, default 48: AXI address width.
REQ-003 SHALL have parameter DATA_W, default 256: AXI data width.
REQ-004 SHALL have parameter MAX_OUTST, default 8: maximum bursts in flight, a power of 2.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port s_araddr, input, NUM_REQ*ADDR_W: per-requester burst address; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port s_arlen, input, NUM_REQ*8: per-requester burst length minus 1.
REQ-009 SHALL have ports s_arvalid (input) and s_arready (output), each NUM_REQ: per-requester AR handshake.
REQ-010 SHALL have ports s_rdata (output, NUM_REQ*DATA_W), s_rresp (output, NUM_REQ*2) and s_rlast (output, NUM_REQ): per-requester read data.
REQ-011 SHALL have ports s_rvalid (output) and s_rready (input), each NUM_REQ: per-requester R handshake.
REQ-012 SHALL have ports m_axi_araddr (ADDR_W), m_axi_arlen (8), m_axi_arsize (3), m_axi_arburst (2) and m_axi_arvalid (1) as outputs, and m_axi_arready (1) as input: shared HBM AR channel.
REQ-013 SHALL have ports m_axi_rdata (DATA_W), m_axi_rresp (2), m_axi_rlast (1) and m_axi_rvalid (1) as inputs, and m_axi_rready (1) as output: shared HBM R channel.
REQ-014 SHALL have port err_unexp_r, output, 1: sticky flag, set when R data arrives with no burst outstanding.

Function
REQ-015 SHALL drive m_axi_arsize with constant 3'b101 (32 B beats) and m_axi_arburst with constant 2'b01 (INCR).
REQ-016 SHALL grant at most one requester per cycle, and only when all of these hold: the AR output stage is empty, or is emptied by an m_axi_ar handshake this cycle; outst_cnt < MAX_OUTST; at least one s_arvalid is asserted.
REQ-017 SHALL select the winner round-robin, searching from index last_grant+1 upward and wrapping NUM_REQ-1 to 0.
REQ-018 SHALL leave last_grant unchanged when no grant occurs.
REQ-019 SHALL assert s_arready[i] combinationally, only in the cycle requester i is granted, so that exactly one bit of s_arready is set per grant.
REQ-020 SHALL, on a grant, register the requester's address, length and index into the AR output stage, and assert m_axi_arvalid in the following cycle (grant-to-arvalid latency 1).
REQ-021 SHALL hold m_axi_arvalid, m_axi_araddr and m_axi_arlen stable until m_axi_arready is sampled high.
REQ-022 SHALL accept a new grant in the same cycle as an m_axi_ar handshake, giving back-to-back issue with no bubble.
REQ-023 SHALL push the granted index into the route FIFO on each m_axi_ar handshake.
REQ-024 SHALL route the R channel to the requester at the route FIFO head: s_rvalid[head] = m_axi_rvalid AND FIFO non-empty; m_axi_rready = s_rready[head].
REQ-025 SHALL hold s_rvalid of every non-head requester at 0.
REQ-026 SHALL broadcast s_rdata, s_rresp and s_rlast to every requester slice.
REQ-027 SHALL pop the route FIFO on an R handshake with m_axi_rlast=1, so the next burst routes from the next cycle.
REQ-028 SHALL maintain outst_cnt: +1 on grant, -1 on last-beat handshake, unchanged when both occur in the same cycle; its range is 0..MAX_OUTST.
REQ-029 SHALL, at outst_cnt == MAX_OUTST, block all grants and hold every s_arready at 0.
REQ-030 SHALL, when the route FIFO is empty and m_axi_rvalid=1, hold m_axi_rready at 0 (stall) and set err_unexp_r; err_unexp_r is cleared only by reset.
REQ-031 SHALL return bursts to requesters in issue order; no reordering.

Reset
REQ-032 SHALL, when rstn=0, asynchronously clear: m_axi_arvalid, stage registers, route FIFO pointers, outst_cnt and err_unexp_r.
REQ-033 SHALL reset last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-034 SHALL, while rstn=0, hold all s_arready, s_rvalid and m_axi_rready at 0.
REQ-035 SHALL, on reset mid-burst, discard in-flight bursts, with no recovery attempted.

Structure
REQ-036 SHALL take shared constants from spmv_pkg: HBM_ADDR_W=48, HBM_DATA_W=256, AXI_BURST_INCR=2'b01, AXI_SIZE_32B=3'b101.
REQ-037 SHALL implement the route FIFO as sub-module hbm_rd_route_fifo (depth MAX_OUTST, width $clog2(NUM_REQ)).

Verification
REQ-038 SHALL cover: single request from requester 2 (addr 0x1000, len 3) -> m_axi_arvalid one cycle after grant with addr 0x1000; 4 beats delivered only on s_rvalid[2].
REQ-039 SHALL cover: all 4 requesters asserting arvalid continuously with arready=1 -> grants issued in order 0,1,2,3,0 on consecutive cycles.
REQ-040 SHALL cover: m_axi_arready held 0 for 5 cycles -> m_axi_araddr/arlen stable, no further s_arready asserted.
REQ-041 SHALL cover: 8 bursts issued with R withheld -> grants blocked; the first rlast handshake unblocks the 9th grant.
REQ-042 SHALL cover: s_rready[head]=0 mid-burst -> m_axi_rready=0 and beat order preserved; a second burst's data is routed only after the first burst's rlast.
REQ-043 SHALL cover: m_axi_rvalid with nothing outstanding -> err_unexp_r=1 and stays 1 until rstn pulse; rstn asserted mid-burst -> all outputs 0 the same cycle.
